// File: rtl/cp0_exc_ctrl.sv
// MIPS CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC, PRId) plus exception,
// ERET and interrupt control. Define CP0_TIMER_EN to build the Count/Compare timer.
module cp0_exc_ctrl #(
   parameter int          HW_INT_NUM = 6,
   parameter int          TIMER_DIV  = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] PRID_VALUE = 32'h0000_4220
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [4:0]            waddr,
   input  logic [31:0]           wdata,
   input  logic [4:0]            raddr,
   output logic [31:0]           rdata,
   input  logic [HW_INT_NUM-1:0] hw_int,
   input  logic                  exc_valid,
   input  logic [4:0]            exc_code,
   input  logic                  exc_bd,
   input  logic [31:0]           exc_pc,
   input  logic [31:0]           exc_badvaddr,
   input  logic                  eret,
   output logic                  int_req,
   output logic                  flush,
   output logic [31:0]           redirect_pc,
   output logic [31:0]           status_o,
   output logic [31:0]           cause_o,
   output logic [31:0]           epc_o
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   generate
      if (HW_INT_NUM < 1 || HW_INT_NUM > 6) begin : g_bad_hw_int
         $error("HW_INT_NUM out of range 1..6");
      end
      if (TIMER_DIV < 1 || TIMER_DIV > 16) begin : g_bad_div
         $error("TIMER_DIV out of range 1..16");
      end
   endgenerate

   logic [31:0] badvaddr_q;
   logic [31:0] epc_q;
   logic [7:0]  im_q;
   logic        exl_q;
   logic        ie_q;
   logic        bd_q;
   logic [4:0]  exc_code_q;
   logic [1:0]  ip_sw_q;
   logic [5:0]  ip_hw_q;
   logic [5:0]  hw_ext;
   logic        ti;
   logic [31:0] count_val;
   logic [31:0] compare_val;
   logic [7:0]  ip_all;

   logic wr_status;
   logic wr_cause;
   logic wr_epc;

   assign wr_status = we && (waddr == REG_STATUS);
   assign wr_cause  = we && (waddr == REG_CAUSE);
   assign wr_epc    = we && (waddr == REG_EPC);

   // Unused interrupt lines are padded with zeros so IP bits beyond HW_INT_NUM read 0.
   always_comb begin
      hw_ext                   = '0;
      hw_ext[HW_INT_NUM-1:0]   = hw_int;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         badvaddr_q <= '0;
         epc_q      <= '0;
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         exc_code_q <= '0;
         ip_sw_q    <= '0;
         ip_hw_q    <= '0;
      end else begin
         ip_hw_q <= hw_ext;
         if (wr_status) begin
            im_q <= wdata[15:8];
            ie_q <= wdata[0];
         end
         if (wr_cause) ip_sw_q <= wdata[9:8];
         // A committing exception owns EXL/BD/ExcCode/EPC; ERET and mtc0 only act without one.
         if (exc_valid) begin
            exl_q      <= 1'b1;
            exc_code_q <= exc_code;
            if (!exl_q) begin
               epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
               bd_q  <= exc_bd;
            end
            if (exc_code == 5'd4 || exc_code == 5'd5) badvaddr_q <= exc_badvaddr;
         end else begin
            if (eret)           exl_q <= 1'b0;
            else if (wr_status) exl_q <= wdata[1];
            if (wr_epc)         epc_q <= wdata;
         end
      end
   end

`ifdef CP0_TIMER_EN
   localparam logic [3:0] PRESC_MAX = 4'(TIMER_DIV - 1);

   logic [3:0]  presc_q;
   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic        ti_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q   <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         if (we && waddr == REG_COUNT) begin
            count_q <= wdata;
            presc_q <= '0;
         end else if (presc_q == PRESC_MAX) begin
            count_q <= count_q + 32'd1;
            presc_q <= '0;
         end else begin
            presc_q <= presc_q + 4'd1;
         end
         // A Compare write clears TI even when it lands on a match cycle.
         if (we && waddr == REG_COMPARE) begin
            compare_q <= wdata;
            ti_q      <= 1'b0;
         end else if (count_q == compare_q && compare_q != 32'd0) begin
            ti_q <= 1'b1;
         end
      end
   end

   assign ti          = ti_q;
   assign count_val   = count_q;
   assign compare_val = compare_q;
`else
   assign ti          = 1'b0;
   assign count_val   = 32'd0;
   assign compare_val = 32'd0;
`endif

   assign ip_all = {ti | ip_hw_q[5], ip_hw_q[4:0], ip_sw_q};

   assign status_o = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_o  = {bd_q, ti, 14'b0, ip_all, 1'b0, exc_code_q, 2'b0};
   assign epc_o    = epc_q;

   always_comb begin
      rdata = 32'd0;
      case (raddr)
         REG_BADVADDR: rdata = badvaddr_q;
         REG_COUNT:    rdata = count_val;
         REG_COMPARE:  rdata = compare_val;
         REG_STATUS:   rdata = status_o;
         REG_CAUSE:    rdata = cause_o;
         REG_EPC:      rdata = epc_q;
         REG_PRID:     rdata = PRID_VALUE;
         default:      rdata = 32'd0;
      endcase
   end

   assign int_req     = ~rst & ie_q & ~exl_q & (|(ip_all & im_q));
   assign flush       = ~rst & (exc_valid | eret);
   assign redirect_pc = (~rst & exc_valid) ? EXC_VECTOR : epc_q;

endmodule
